// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multicycle MIPS datapath.
// The outputs come from the state register only; FETCH also gates its IR/PC load on mem_ready.
module multicycle_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state_out,
  output logic       trap
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RESET;
    else          state <= state_next;
  end

  always_comb begin
    state_next = S_RESET;
    case (state)
      S_RESET:     state_next = S_FETCH;
      S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EXEC;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      // Only LW/SW reach MEM_ADDR, so anything but SW is treated as a load.
      S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      S_ADDI_WB:   state_next = S_FETCH;
      S_ILLEGAL:   state_next = S_ILLEGAL;
      default:     state_next = S_RESET;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    trap        = 1'b0;
    case (state)
      // IR/PC load only on the cycle the fetch completes, so a stall never double-increments PC.
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:    ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b10;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDI_EXEC: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      S_ADDI_WB:   RegWrite = 1'b1;
      S_ILLEGAL:   trap = 1'b1;
      default: ;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected output vectors go through a scoreboard queue.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, trap;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_out;

  int n_assert = 0;
  int n_fail   = 0;
  int pcw_cnt, irw_cnt, memw_cnt, iord_cnt, st4_cnt;
  logic [21:0] sb_q[$];

  multicycle_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state_out(state_out), .trap(trap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packing: {state, trap, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  //           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}
  function automatic logic [21:0] dut_vec();
    return {state_out, trap, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic mr);
    logic tr, pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw;
    logic [1:0] sa, sb, op, ps;
    {tr, pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw} = '0;
    {sa, sb, op, ps} = '0;
    case (st)
      4'd1:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      4'd2:  sb = 2'b11;
      4'd3:  begin sa = 2'b10; sb = 2'b10; end
      4'd4:  begin mrd = 1; iord = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mwr = 1; iord = 1; end
      4'd7:  begin sa = 2'b10; op = 2'b10; end
      4'd8:  begin rw = 1; rdst = 1; end
      4'd9:  begin sa = 2'b10; op = 2'b01; pwc = 1; ps = 2'b01; end
      4'd10: begin pw = 1; ps = 2'b10; end
      4'd11: begin sa = 2'b10; sb = 2'b10; end
      4'd12: rw = 1;
      4'd13: tr = 1;
      default: ;
    endcase
    return {st, tr, pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, op, ps};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_and_check(input string tag);
    logic [21:0] e;
    e = sb_q.pop_front();
    check(tag, {10'd0, dut_vec()}, {10'd0, e});
  endtask

  // One clock cycle: drive inputs after the falling edge, push expectation, compare before the rising edge.
  task automatic cyc(input logic [5:0] op, input logic mr, input logic [3:0] st, input string tag);
    @(negedge clk);
    opcode    = op;
    mem_ready = mr;
    sb_q.push_back(exp_vec(st, mr));
    #1;
    pop_and_check(tag);
    check({tag, "_excl"}, {30'd0, MemRead & MemWrite, PCWrite & PCWriteCond}, 32'd0);
    pcw_cnt  += int'(PCWrite);
    irw_cnt  += int'(IRWrite);
    memw_cnt += int'(MemWrite);
    if (state_out == 4'd4) begin
      st4_cnt  += 1;
      iord_cnt += int'(IorD);
    end
  endtask

  task automatic clr_cnt();
    pcw_cnt = 0; irw_cnt = 0; memw_cnt = 0; iord_cnt = 0; st4_cnt = 0;
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
    clr_cnt();

    cyc(6'h00, 1'b0, 4'd0, "reset_state");
    reset_n = 1'b1;

    // R-type: 1,2,7,8 then back to FETCH
    cyc(6'h00, 1'b1, 4'd1, "r_fetch");
    cyc(6'h00, 1'b1, 4'd2, "r_decode");
    cyc(6'h3F, 1'b0, 4'd7, "r_exec");
    cyc(6'h3F, 1'b0, 4'd8, "r_wb");

    // LW with three wait cycles in MEM_READ
    clr_cnt();
    cyc(6'h23, 1'b1, 4'd1, "lw_fetch");
    cyc(6'h23, 1'b1, 4'd2, "lw_decode");
    cyc(6'h23, 1'b0, 4'd3, "lw_addr");
    cyc(6'h00, 1'b0, 4'd4, "lw_rd0");
    cyc(6'h00, 1'b0, 4'd4, "lw_rd1");
    cyc(6'h00, 1'b0, 4'd4, "lw_rd2");
    cyc(6'h00, 1'b1, 4'd4, "lw_rd3");
    cyc(6'h00, 1'b0, 4'd5, "lw_wb");
    check("lw_st4_cycles", st4_cnt, 4);
    check("lw_iord_cycles", iord_cnt, 4);
    check("lw_pcwrite_once", pcw_cnt, 1);

    // FETCH stall two cycles, then BEQ
    clr_cnt();
    cyc(6'h04, 1'b0, 4'd1, "stall0");
    cyc(6'h04, 1'b0, 4'd1, "stall1");
    check("stall_no_load", pcw_cnt + irw_cnt, 0);
    cyc(6'h04, 1'b1, 4'd1, "stall_done");
    check("stall_pcw_pulse", pcw_cnt, 1);
    check("stall_irw_pulse", irw_cnt, 1);
    cyc(6'h04, 1'b1, 4'd2, "beq_decode");
    cyc(6'h00, 1'b1, 4'd9, "beq_branch");

    // J
    cyc(6'h02, 1'b1, 4'd1, "j_fetch");
    cyc(6'h02, 1'b1, 4'd2, "j_decode");
    cyc(6'h00, 1'b1, 4'd10, "j_jump");

    // ADDI
    cyc(6'h08, 1'b1, 4'd1, "addi_fetch");
    cyc(6'h08, 1'b1, 4'd2, "addi_decode");
    cyc(6'h00, 1'b1, 4'd11, "addi_exec");
    cyc(6'h00, 1'b1, 4'd12, "addi_wb");

    // SW, memory ready immediately
    clr_cnt();
    cyc(6'h2B, 1'b1, 4'd1, "sw_fetch");
    cyc(6'h2B, 1'b1, 4'd2, "sw_decode");
    cyc(6'h2B, 1'b1, 4'd3, "sw_addr");
    cyc(6'h00, 1'b1, 4'd6, "sw_write");
    cyc(6'h00, 1'b1, 4'd1, "sw_next_fetch");
    check("sw_memwrite_once", memw_cnt, 1);

    // Asynchronous reset in the middle of MEM_READ
    cyc(6'h23, 1'b1, 4'd2, "rst_lw_decode");
    cyc(6'h23, 1'b0, 4'd3, "rst_lw_addr");
    cyc(6'h23, 1'b0, 4'd4, "rst_lw_read");
    #1 reset_n = 1'b0;
    #1;
    sb_q.push_back(exp_vec(4'd0, 1'b0));
    pop_and_check("async_reset");
    reset_n = 1'b1;
    cyc(6'h00, 1'b0, 4'd1, "post_reset_fetch");

    // Illegal opcode: trap holds for 20 cycles, only reset clears it
    cyc(6'h3F, 1'b1, 4'd1, "ill_fetch");
    cyc(6'h3F, 1'b1, 4'd2, "ill_decode");
    for (int i = 0; i < 20; i++)
      cyc(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 4'd13, "ill_hold");
    #1 reset_n = 1'b0;
    #1;
    sb_q.push_back(exp_vec(4'd0, 1'b0));
    pop_and_check("ill_reset");
    reset_n = 1'b1;
    cyc(6'h00, 1'b1, 4'd1, "ill_recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
